// File: rtl/counter_delayed_trigger.sv
// counter_delayed_trigger
// Period cycle counter with an armable one-shot trigger that fires
// `presamples` counts ahead of `reference_counter`, plus capture of the
// length of the last completed period.
module counter_delayed_trigger (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        arm,
    input  logic        trigger_reset,
    input  logic        counter_reset,
    input  logic [31:0] presamples,
    input  logic [31:0] reference_counter,
    output logic        trigger,
    output logic        armed_status,
    output logic [31:0] last_counter
);

    logic [31:0] counter_q, counter_d;
    logic [31:0] last_counter_q, last_counter_d;
    logic        armed_q, armed_d;
    logic        trigger_q, trigger_d;
    logic        counter_reset_q, counter_reset_d;

    logic [31:0] target;
    logic        fire;
    logic        period_start;

    // Next-state logic: counter, period capture, arm/fire/clear handling.
    always_comb begin
        target          = reference_counter - presamples;
        fire            = armed_q && enable && !counter_reset && (counter_q == target);
        period_start    = counter_reset && !counter_reset_q;

        counter_d       = counter_q;
        last_counter_d  = last_counter_q;
        armed_d         = armed_q;
        trigger_d       = trigger_q;
        counter_reset_d = counter_reset;

        if (counter_reset) begin
            counter_d = 32'd0;
        end else if (enable) begin
            counter_d = counter_q + 32'd1;
        end

        if (period_start) begin
            last_counter_d = counter_q;
        end

        if (trigger_reset) begin
            trigger_d = 1'b0;
            armed_d   = 1'b0;
        end else if (fire) begin
            trigger_d = 1'b1;
            armed_d   = 1'b0;
        end else if (arm && !trigger_q) begin
            armed_d   = 1'b1;
        end
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge aresetn) begin
        if (aresetn) begin
            counter_q       <= 32'd0;
            last_counter_q  <= 32'd0;
            armed_q         <= 1'b0;
            trigger_q       <= 1'b0;
            counter_reset_q <= 1'b0;
        end else begin
            counter_q       <= counter_d;
            last_counter_q  <= last_counter_d;
            armed_q         <= armed_d;
            trigger_q       <= trigger_d;
            counter_reset_q <= counter_reset_d;
        end
    end

    assign trigger      = trigger_q;
    assign armed_status = armed_q;
    assign last_counter = last_counter_q;

endmodule

// File: tb/tb_counter_delayed_trigger.sv
// Testbench for counter_delayed_trigger: directed scenarios followed by a
// randomized run, all checked against a behavioural model of the rules.
module tb_counter_delayed_trigger;

    logic        clk;
    logic        aresetn;
    logic        enable;
    logic        arm;
    logic        trigger_reset;
    logic        counter_reset;
    logic [31:0] presamples;
    logic [31:0] reference_counter;
    logic        trigger;
    logic        armed_status;
    logic [31:0] last_counter;

    int n_checks;
    int n_fail;

    // Behavioural model state
    logic [31:0] m_count;
    logic [31:0] m_last;
    logic        m_armed;
    logic        m_trig;
    logic        m_cr_prev;

    counter_delayed_trigger dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .enable            (enable),
        .arm               (arm),
        .trigger_reset     (trigger_reset),
        .counter_reset     (counter_reset),
        .presamples        (presamples),
        .reference_counter (reference_counter),
        .trigger           (trigger),
        .armed_status      (armed_status),
        .last_counter      (last_counter)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_count   = 32'd0;
        m_last    = 32'd0;
        m_armed   = 1'b0;
        m_trig    = 1'b0;
        m_cr_prev = 1'b0;
    endtask

    // One clock of the reference behaviour, using the inputs seen at the edge.
    task automatic modelStep();
        logic [31:0] target;
        logic        hit;
        target = reference_counter - presamples;
        hit    = m_armed && enable && !counter_reset && (m_count == target);
        if (counter_reset && !m_cr_prev) m_last = m_count;
        m_cr_prev = counter_reset;
        if (counter_reset)   m_count = 32'd0;
        else if (enable)     m_count = m_count + 32'd1;
        if (trigger_reset) begin
            m_trig  = 1'b0;
            m_armed = 1'b0;
        end else if (hit) begin
            m_trig  = 1'b1;
            m_armed = 1'b0;
        end else if (arm && !m_trig) begin
            m_armed = 1'b1;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".trigger"}, {31'd0, trigger}, {31'd0, m_trig});
        checkOutput({tag, ".armed"}, {31'd0, armed_status}, {31'd0, m_armed});
        checkOutput({tag, ".last"}, last_counter, m_last);
    endtask

    // Advance one clock with the currently driven inputs, then check.
    task automatic applyStimulus(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkModel(tag);
    endtask

    task automatic pulseCounterReset(input string tag);
        counter_reset = 1'b1;
        applyStimulus(tag);
        counter_reset = 1'b0;
    endtask

    task automatic pulseTriggerReset(input string tag);
        trigger_reset = 1'b1;
        applyStimulus(tag);
        trigger_reset = 1'b0;
    endtask

    // Step until trigger rises, arming once at edge index armAt; returns edge count.
    task automatic runUntilTrigger(input string tag, input int maxc, input int armAt, output int edges);
        edges = 0;
        while (edges < maxc) begin
            arm = (edges == armAt);
            applyStimulus(tag);
            edges++;
            if (trigger === 1'b1) break;
        end
        arm = 1'b0;
    endtask

    task automatic runCycles(input string tag, input int n, input int armAt);
        for (int i = 0; i < n; i++) begin
            arm = (i == armAt);
            applyStimulus(tag);
        end
        arm = 1'b0;
    endtask

    // Asynchronous reset asserted between edges, held across one edge.
    task automatic asyncReset(input string tag);
        #2;
        aresetn = 1'b1;
        #1;
        modelReset();
        checkModel({tag, ".async"});
        @(posedge clk);
        #1;
        checkModel({tag, ".held"});
        aresetn = 1'b0;
    endtask

    // Directed scenarios then randomized checking against the model.
    initial begin
        int edges;
        n_checks          = 0;
        n_fail            = 0;
        aresetn           = 1'b1;
        enable            = 1'b0;
        arm               = 1'b0;
        trigger_reset     = 1'b0;
        counter_reset     = 1'b0;
        presamples        = 32'd0;
        reference_counter = 32'd0;
        modelReset();

        // Reset state
        #1;
        checkModel("reset");
        enable = 1'b1;
        arm    = 1'b1;
        @(posedge clk);
        #1;
        checkModel("reset_hold");
        arm     = 1'b0;
        aresetn = 1'b0;

        // Counter counts from 0 after release: 20 edges then capture
        runCycles("count_from_0", 20, -1);
        pulseCounterReset("count_cap");
        checkOutput("count_from_0.last", last_counter, 32'd20);

        // Basic fire: target 200, trigger 201 edges after release
        reference_counter = 32'd250;
        presamples        = 32'd50;
        pulseCounterReset("basic_cr");
        runUntilTrigger("basic", 400, 10, edges);
        checkOutput("basic.fire_edge", edges, 32'd201);
        checkOutput("basic.armed_low", {31'd0, armed_status}, 32'd0);
        pulseCounterReset("basic_hold");
        checkOutput("basic.trig_through_cr", {31'd0, trigger}, 32'd1);

        // Arm ignored while trigger high, then rearm mid-period
        arm = 1'b1;
        applyStimulus("arm_ignored");
        arm = 1'b0;
        checkOutput("arm_ignored.armed", {31'd0, armed_status}, 32'd0);
        pulseTriggerReset("rearm_tr");
        checkOutput("rearm_tr.trigger", {31'd0, trigger}, 32'd0);
        pulseCounterReset("rearm_cr");
        runUntilTrigger("rearm", 400, 138, edges);
        checkOutput("rearm.fire_edge", edges, 32'd201);

        // Period capture: 500 enabled edges between pulses
        pulseCounterReset("period_cr0");
        runCycles("period", 500, -1);
        pulseCounterReset("period_cr1");
        checkOutput("period.last", last_counter, 32'd500);

        // Enable low while counter sits at target: no fire
        pulseTriggerReset("en_tr");
        pulseCounterReset("en_cr");
        runCycles("en_run", 200, 5);
        enable = 1'b0;
        runCycles("en_frozen", 50, -1);
        checkOutput("en_frozen.trigger", {31'd0, trigger}, 32'd0);
        checkOutput("en_frozen.armed", {31'd0, armed_status}, 32'd1);
        pulseCounterReset("en_cr_low");
        checkOutput("en_cr_low.last", last_counter, 32'd200);
        enable = 1'b1;
        runUntilTrigger("en_resume", 400, -1, edges);
        checkOutput("en_resume.fire_edge", edges, 32'd201);

        // trigger_reset beats a simultaneous fire
        pulseTriggerReset("prio_tr0");
        pulseCounterReset("prio_cr");
        runCycles("prio_run", 200, 5);
        pulseTriggerReset("prio_tr1");
        checkOutput("prio.trigger", {31'd0, trigger}, 32'd0);
        checkOutput("prio.armed", {31'd0, armed_status}, 32'd0);
        runCycles("prio_after", 10, -1);

        // Wrapped target 0xFFFFFFCE never reached in a short period
        presamples        = 32'd300;
        reference_counter = 32'd250;
        pulseCounterReset("wrap_cr");
        runCycles("wrap", 1000, 3);
        checkOutput("wrap.trigger", {31'd0, trigger}, 32'd0);
        checkOutput("wrap.armed", {31'd0, armed_status}, 32'd1);

        // Mid-operation asynchronous reset
        asyncReset("mid");

        // Randomized run with short periods so targets are actually reached
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                reference_counter = $urandom % 80;
                presamples        = ($urandom % 8 == 0) ? reference_counter + 32'd5
                                                        : $urandom % (reference_counter + 32'd1);
            end
            enable        = ($urandom % 10) != 0;
            arm           = ($urandom % 15) == 0;
            trigger_reset = ($urandom % 90) == 0;
            counter_reset = ($urandom % 60) == 0;
            applyStimulus("rand");
            if (i % 1000 == 777) asyncReset("rand");
        end
        enable        = 1'b0;
        arm           = 1'b0;
        trigger_reset = 1'b0;
        counter_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
